// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder; the requester drives the master side.
// Handshake is start-pulse in, done-pulse out; there is no ready, so start is dropped while busy.
interface serial_adder_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: one full-adder cell, registered carry, LSB first; done W edges after start.
// No backpressure: start is accepted in IDLE or DONE only and ignored while busy.
module serial_adder #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_sh_q, a_sh_d;
  logic [W-1:0]  b_sh_q, b_sh_d;
  logic [W-1:0]  s_sh_q, s_sh_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;

  logic fa_s;
  logic fa_co;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // The single full-adder cell shared by every bit position.
  always_comb begin
    fa_s  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    fa_co = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        s_sh_d    = s_sh_q >> 1;
        s_sh_d[W-1] = fa_s;
        carry_d   = fa_co;
        cnt_d     = cnt_q + 1'b1;
        // Last bit: publish the sum including the bit produced on this edge.
        if (cnt_q == LAST) begin
          sum_d   = s_sh_d;
          cout_d  = fa_co;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = (state_q == DONE);
    bus.sum  = sum_q;
    bus.cout = cout_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: stimulus pushes expected {sum,cout,done cycle} into a queue,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_adder;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_adder_if #(.W(W)) bus ();

  serial_adder #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    int unsigned  at;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 with no outstanding transaction (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("sum", 32'(bus.sum), 32'(e.s));
        chk("cout", 32'(bus.cout), 32'(e.c));
        chk("done_cycle", cyc, e.at);
      end
    end
  end

  // One-cycle start at a negedge; the capture edge is the next posedge.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                       input logic [W-1:0] es, input logic ec, input bit push);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    bus.cin   = ci;
    if (push) begin
      e.s  = es;
      e.c  = ec;
      e.at = cyc + 1 + W;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (exp_q.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d results outstanding", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_outputs(input string tag, input logic [W-1:0] es, input logic ec);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_sum"}, 32'(bus.sum), 32'(es));
    chk({tag, "_cout"}, 32'(bus.cout), 32'(ec));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int bc;
    exp_t e;

    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.a     = 8'hAA;
    bus.b     = 8'h00;
    bus.cin   = 1'b0;

    // Reset held with start asserted: nothing may start.
    repeat (3) begin
      @(negedge clk);
      chk_outputs("reset", 8'h00, 1'b0);
    end
    bus.start = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    chk_outputs("post_reset", 8'h00, 1'b0);

    // Basic add with busy-window length.
    issue(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1);
    bc = 0;
    for (int t = 0; t < 40; t++) begin
      if (bus.busy === 1'b1) bc++;
      if (bus.done === 1'b1) break;
      @(negedge clk);
    end
    chk("busy_cycles", bc, 32'd8);
    wait_done();

    // Carry ripple through every bit, then max operands with carry-in.
    issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1);
    wait_done();
    issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1);
    wait_done();

    // Start pulse in RUN cycle 3 is ignored; previous result holds while busy.
    issue(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1);
    for (int i = 0; i < 7; i++) begin
      chk("hold_sum", 32'(bus.sum), 32'h0000_00FF);
      chk("hold_cout", 32'(bus.cout), 32'd1);
      if (i == 2) begin
        bus.start = 1'b1;
        bus.a     = 8'hF0;
        bus.b     = 8'hF0;
      end
      if (i == 3) bus.start = 1'b0;
      @(negedge clk);
    end
    wait_done();
    repeat (12) @(negedge clk);

    // Back-to-back with start held high; new operands appear in the DONE cycle.
    @(negedge clk);
    n         = cyc;
    bus.start = 1'b1;
    bus.a     = 8'h01;
    bus.b     = 8'h01;
    bus.cin   = 1'b0;
    e.s = 8'h02; e.c = 1'b0; e.at = n + 1 + W;
    exp_q.push_back(e);
    repeat (W + 1) @(negedge clk);
    bus.a = 8'h80;
    bus.b = 8'h80;
    e.s = 8'h00; e.c = 1'b1; e.at = n + 1 + W + (W + 1);
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // Reset in RUN cycle 4 aborts with no done and clears outputs.
    issue(8'h55, 8'h55, 1'b0, 8'h00, 1'b0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_outputs("abort", 8'h00, 1'b0);
    repeat (12) @(negedge clk);
    chk_outputs("abort_idle", 8'h00, 1'b0);
    issue(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1);
    wait_done();

    // A few more patterns: full overflow with carry-in and carry-in only.
    issue(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1);
    wait_done();
    issue(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1);
    wait_done();
    issue(8'hC3, 8'h5A, 1'b0, 8'h1D, 1'b1, 1);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
